// File: rtl/pwm_ramp_sequencer.sv
// Shared PWM duty ramp and device hand-over sequencer (soft start/stop, dead time).
// Optional macro LED_NO_RAMP_EN: the LED skips ramping in both directions.
module pwm_ramp_sequencer #(
  parameter int unsigned RAMP_DIV   = 50000,
  parameter int unsigned RAMP_STEP  = 250,
  parameter int unsigned DEAD_TICKS = 10,
  parameter int unsigned DUTY_MAX   = 25000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_boton_sel,
  input  logic [14:0] i_pwm_target,
  output logic [14:0] o_pwm_duty,
  output logic [1:0]  o_sel_active,
  output logic        o_busy
);

  localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DW = $clog2(DEAD_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_TICKS - 1);
  localparam logic [15:0]   STEP16     = 16'(RAMP_STEP);
  localparam logic [14:0]   DUTY_CLAMP = 15'(DUTY_MAX);

  typedef enum logic [1:0] {IDLE, TRACK, RAMP_DOWN, DEAD} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [DW-1:0]   r_dead_cnt;
  logic [14:0]     r_duty;
  logic [1:0]      r_sel;

  logic            w_tick;
  logic            w_led_fast;
  logic [14:0]     w_tgt;
  logic [15:0]     w_diff_up;
  logic [15:0]     w_diff_dn;
  logic [15:0]     w_step_up;
  logic [15:0]     w_step_dn;
  logic [15:0]     w_step_zero;
  logic [14:0]     w_duty_track;
  logic [14:0]     w_duty_down;

  // Steps are limited to the remaining distance so duty never overshoots or wraps.
  always_comb begin
    w_tick      = (r_presc == PRESC_LAST);
    w_tgt       = (i_pwm_target > DUTY_CLAMP) ? DUTY_CLAMP : i_pwm_target;
    w_diff_up   = {1'b0, w_tgt} - {1'b0, r_duty};
    w_diff_dn   = {1'b0, r_duty} - {1'b0, w_tgt};
    w_step_up   = (w_diff_up > STEP16) ? STEP16 : w_diff_up;
    w_step_dn   = (w_diff_dn > STEP16) ? STEP16 : w_diff_dn;
    w_step_zero = ({1'b0, r_duty} > STEP16) ? STEP16 : {1'b0, r_duty};
    w_duty_track = (r_duty < w_tgt) ? 15'({1'b0, r_duty} + w_step_up)
                                    : 15'({1'b0, r_duty} - w_step_dn);
    w_duty_down  = 15'({1'b0, r_duty} - w_step_zero);
`ifdef LED_NO_RAMP_EN
    w_led_fast = (r_sel == 2'b11);
`else
    w_led_fast = 1'b0;
`endif
    o_busy = (r_state == RAMP_DOWN) || (r_state == DEAD) ||
             ((r_state == TRACK) && (r_duty != w_tgt));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_duty     <= '0;
      r_sel      <= '0;
      r_dead_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_duty <= '0;
          r_sel  <= i_boton_sel;
          if (i_boton_sel != 2'b00) r_state <= TRACK;
        end
        TRACK: begin
          if (i_boton_sel != r_sel) begin
            r_state <= RAMP_DOWN;
          end else if (w_led_fast) begin
            r_duty <= w_tgt;
          end else if (w_tick) begin
            r_duty <= w_duty_track;
          end
        end
        RAMP_DOWN: begin
          // Abort has priority over the duty==0 hand-over.
          if (i_boton_sel == r_sel) begin
            r_state <= TRACK;
          end else if (r_duty == '0) begin
            r_sel      <= '0;
            r_dead_cnt <= '0;
            r_state    <= DEAD;
          end else if (w_led_fast) begin
            r_duty <= '0;
          end else if (w_tick) begin
            r_duty <= w_duty_down;
          end
        end
        DEAD: begin
          r_duty <= '0;
          if (w_tick) begin
            if (r_dead_cnt == DEAD_LAST) begin
              r_sel   <= i_boton_sel;
              r_state <= (i_boton_sel == 2'b00) ? IDLE : TRACK;
            end else begin
              r_dead_cnt <= r_dead_cnt + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_pwm_duty   = r_duty;
  assign o_sel_active = r_sel;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed vector table plus randomized run
// against a cycle-level behavioural model.
module tb_pwm_ramp_sequencer;

  localparam int DIV  = 4;
  localparam int STEP = 100;
  localparam int DT   = 2;
  localparam int DMAX = 1000;
`ifdef LED_NO_RAMP_EN
  localparam bit LED_NR = 1'b1;
`else
  localparam bit LED_NR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  boton = 2'b00;
  logic [14:0] target = '0;
  logic [14:0] duty;
  logic [1:0]  sel;
  logic        busy;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(
    .RAMP_DIV(DIV), .RAMP_STEP(STEP), .DEAD_TICKS(DT), .DUTY_MAX(DMAX)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_boton_sel(boton), .i_pwm_target(target),
    .o_pwm_duty(duty), .o_sel_active(sel), .o_busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 idle, 1 following target, 2 winding down, 3 dead time.
  int m_presc, m_phase, m_duty, m_sel, m_dcnt;
  int prev_sel = 0;

  typedef struct {
    int sel_in; int tgt_in; int cycles;
    int duty; int sel; int busy;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic int clamp(input int t);
    return (t > DMAX) ? DMAX : t;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_phase = 0; m_duty = 0; m_sel = 0; m_dcnt = 0;
  endtask

  task automatic model_step();
    bit tick;
    int tg, b;
    tick = (m_presc == DIV - 1);
    m_presc = tick ? 0 : m_presc + 1;
    tg = clamp(int'(target));
    b  = int'(boton);
    case (m_phase)
      0: begin
        m_duty = 0; m_sel = b;
        if (b != 0) m_phase = 1;
      end
      1: begin
        if (b != m_sel) m_phase = 2;
        else if (LED_NR && m_sel == 3) m_duty = tg;
        else if (tick) begin
          if (m_duty < tg) m_duty += min2(STEP, tg - m_duty);
          else m_duty -= min2(STEP, m_duty - tg);
        end
      end
      2: begin
        if (b == m_sel) m_phase = 1;
        else if (m_duty == 0) begin m_sel = 0; m_dcnt = 0; m_phase = 3; end
        else if (LED_NR && m_sel == 3) m_duty = 0;
        else if (tick) m_duty -= min2(STEP, m_duty);
      end
      default: begin
        if (tick) begin
          m_dcnt++;
          if (m_dcnt == DT) begin
            m_sel = b;
            m_phase = (b == 0) ? 0 : 1;
          end
        end
      end
    endcase
  endtask

  task automatic check_model();
    int exp_busy;
    exp_busy = (m_phase == 2 || m_phase == 3 ||
                (m_phase == 1 && m_duty != clamp(int'(target)))) ? 1 : 0;
    chk("model_duty", int'(duty), m_duty);
    chk("model_sel", int'(sel), m_sel);
    chk("model_busy", int'(busy), exp_busy);
    chk("sel_direct_hop", (prev_sel != 0 && sel != 0 && int'(sel) != prev_sel) ? 1 : 0, 0);
    prev_sel = int'(sel);
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      check_model();
    end
  endtask

  function automatic void add(input int s, input int t, input int c,
                              input int d, input int se, input int bu);
    vec_t v;
    v.sel_in = s; v.tgt_in = t; v.cycles = c; v.duty = d; v.sel = se; v.busy = bu;
    vecs.push_back(v);
  endfunction

  initial begin
    // Soft start to 350
    add(1, 350, 1, 0, 1, 1);    add(1, 350, 3, 100, 1, 1);
    add(1, 350, 4, 200, 1, 1);  add(1, 350, 4, 300, 1, 1);
    add(1, 350, 4, 350, 1, 0);
    // Hand-over 01 -> 10 with dead time
    add(2, 350, 1, 350, 1, 1);  add(2, 350, 3, 250, 1, 1);
    add(2, 350, 4, 150, 1, 1);  add(2, 350, 4, 50, 1, 1);
    add(2, 350, 4, 0, 1, 1);    add(2, 350, 1, 0, 0, 1);
    add(2, 350, 6, 0, 0, 1);    add(2, 350, 1, 0, 2, 1);
    add(2, 350, 4, 100, 2, 1);  add(2, 350, 12, 350, 2, 0);
    // Aborted hand-over
    add(1, 350, 1, 350, 2, 1);  add(1, 350, 3, 250, 2, 1);
    add(1, 350, 4, 150, 2, 1);  add(2, 350, 1, 150, 2, 1);
    add(2, 350, 3, 250, 2, 1);  add(2, 350, 4, 350, 2, 0);
    // Clamp at DUTY_MAX, then ramp down to a non-multiple target
    add(2, 5000, 28, 1000, 2, 0); add(2, 5000, 8, 1000, 2, 0);
    add(2, 120, 4, 900, 2, 1);    add(2, 120, 28, 200, 2, 1);
    add(2, 120, 4, 120, 2, 0);
    // Hand-over to LED
    add(3, 700, 1, 120, 2, 1);  add(3, 700, 3, 20, 2, 1);
    add(3, 700, 4, 0, 2, 1);    add(3, 700, 1, 0, 0, 1);
    add(3, 700, 7, 0, 3, 1);
    if (LED_NR) begin
      add(3, 700, 1, 700, 3, 0);
    end else begin
      add(3, 700, 4, 100, 3, 1);
      add(3, 700, 24, 700, 3, 0);
    end

    model_reset();
    boton = 2'd1; target = 15'd350;
    #1;
    chk("reset_duty", int'(duty), 0);
    chk("reset_sel", int'(sel), 0);
    chk("reset_busy", int'(busy), 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;

    foreach (vecs[i]) begin
      boton  = 2'(vecs[i].sel_in);
      target = 15'(vecs[i].tgt_in);
      cyc(vecs[i].cycles);
      chk($sformatf("vec%0d_duty", i), int'(duty), vecs[i].duty);
      chk($sformatf("vec%0d_sel", i), int'(sel), vecs[i].sel);
      chk($sformatf("vec%0d_busy", i), int'(busy), vecs[i].busy);
    end

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) boton = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0)
        target = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(1001, 32767))
                                             : 15'($urandom_range(0, 1000));
      cyc(1);
    end

    // Reset asserted between edges while ramping
    boton = 2'd1; target = 15'd1000;
    cyc(70);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_sel", int'(sel), 0);
    chk("midrst_busy", int'(busy), 0);
    prev_sel = 0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    target = 15'd350;
    cyc(3);
    chk("postrst_no_tick", int'(duty), 0);
    chk("postrst_sel", int'(sel), 1);
    cyc(1);
    chk("postrst_first_tick", int'(duty), 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
